// File: rtl/uint_to_float_pkg.sv
// Shared FP32 field widths, encoding type and constants for the integer-to-float pipeline.
package uint_to_float_pkg;

  localparam int unsigned FP32_BIAS   = 127;
  localparam int unsigned FP32_MANT_W = 23;
  localparam int unsigned FP32_EXP_W  = 8;

  typedef struct packed {
    logic                   sign;
    logic [FP32_EXP_W-1:0]  exp;
    logic [FP32_MANT_W-1:0] mant;
  } fp32_t;

  localparam fp32_t FP32_ZERO = '{sign: 1'b0, exp: '0, mant: '0};

endpackage

// File: rtl/leading_zero_count.sv
// Combinational leading-zero counter; an all-zero input yields WIDTH.
module leading_zero_count
  import uint_to_float_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  localparam int unsigned CntW = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [CntW-1:0]  count_o
);

  // Scanning upward lets the highest set bit win.
  always_comb begin
    count_o = CntW'(WIDTH);
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (data_i[i]) count_o = CntW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/uint_to_float_pipe.sv
// Three-stage integer to IEEE-754 single converter with tag sideband and valid/ready flow.
// Define UINT_TO_FLOAT_SIGNED_EN to treat in_data as two's complement.
module uint_to_float_pipe
  import uint_to_float_pkg::*;
#(
  parameter int unsigned INT_WIDTH = 16,
  parameter int unsigned TAG_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [INT_WIDTH-1:0] in_data,
  input  logic [TAG_WIDTH-1:0] in_tag,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [31:0]          out_float,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int unsigned LzcW  = $clog2(INT_WIDTH + 1);
  localparam int unsigned FracW = INT_WIDTH - 1;

  logic                   s1_valid_q, s2_valid_q, s3_valid_q;
  logic                   s1_en, s2_en, s3_en;
  logic                   s1_sign_d, s1_sign_q, s2_sign_q;
  logic [INT_WIDTH-1:0]   s1_mag_d, s1_mag_q, s2_mag_q;
  logic [LzcW-1:0]        lzc, s2_lzc_q;
  logic [TAG_WIDTH-1:0]   s1_tag_q, s2_tag_q, s3_tag_q;
  logic [FracW-1:0]       frac;
  logic [FP32_EXP_W-1:0]  exp_raw;
  logic [FP32_MANT_W-1:0] mant;
  logic                   mant_carry;
  fp32_t                  s3_float_d, s3_float_q;

  // A stage loads when empty or when its contents leave this cycle.
  assign s3_en    = !s3_valid_q || out_ready;
  assign s2_en    = !s2_valid_q || s3_en;
  assign s1_en    = !s1_valid_q || s2_en;
  assign in_ready = s1_en;

  // S1: magnitude and sign.
`ifdef UINT_TO_FLOAT_SIGNED_EN
  assign s1_sign_d = in_data[INT_WIDTH-1];
  assign s1_mag_d  = s1_sign_d ? -in_data : in_data;
`else
  assign s1_sign_d = 1'b0;
  assign s1_mag_d  = in_data;
`endif

  // S2: leading-zero count.
  leading_zero_count #(
    .WIDTH (INT_WIDTH)
  ) u_lzc (
    .data_i  (s1_mag_q),
    .count_o (lzc)
  );

  // S3: normalise, drop the leading one, round and pack.
  assign frac    = FracW'(s2_mag_q << s2_lzc_q);
  assign exp_raw = FP32_EXP_W'(FP32_BIAS + FracW) - FP32_EXP_W'(s2_lzc_q);

  if (INT_WIDTH <= 24) begin : g_exact
    assign mant       = FP32_MANT_W'(frac) << (FP32_MANT_W - FracW);
    assign mant_carry = 1'b0;
  end else begin : g_round
    logic [30:0] aligned;
    logic        round_up;
    // Fraction left-justified: bits 30:8 mantissa, 7 guard, 6:0 sticky.
    assign aligned  = 31'(frac) << (31 - FracW);
    assign round_up = aligned[7] & ((|aligned[6:0]) | aligned[8]);
    assign {mant_carry, mant} = {1'b0, aligned[30:8]} + 24'(round_up);
  end

  always_comb begin
    s3_float_d = FP32_ZERO;
    if (s2_mag_q != '0) begin
      s3_float_d.sign = s2_sign_q;
      // A carry-out leaves the mantissa at zero; only the exponent moves.
      s3_float_d.exp  = exp_raw + FP32_EXP_W'(mant_carry);
      s3_float_d.mant = mant;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s2_sign_q  <= 1'b0;
      s1_mag_q   <= '0;
      s2_mag_q   <= '0;
      s2_lzc_q   <= '0;
      s1_tag_q   <= '0;
      s2_tag_q   <= '0;
      s3_tag_q   <= '0;
      s3_float_q <= FP32_ZERO;
    end else begin
      if (s1_en) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_sign_q <= s1_sign_d;
          s1_mag_q  <= s1_mag_d;
          s1_tag_q  <= in_tag;
        end
      end
      if (s2_en) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_sign_q <= s1_sign_q;
          s2_mag_q  <= s1_mag_q;
          s2_lzc_q  <= lzc;
          s2_tag_q  <= s1_tag_q;
        end
      end
      if (s3_en) begin
        s3_valid_q <= s2_valid_q;
        if (s2_valid_q) begin
          s3_float_q <= s3_float_d;
          s3_tag_q   <= s2_tag_q;
        end
      end
    end
  end

  assign out_valid = s3_valid_q;
  assign out_float = s3_float_q;
  assign out_tag   = s3_tag_q;

endmodule
